// File: rtl/kulisch_seq_accumulator_pkg.sv
// rtl/kulisch_seq_accumulator_pkg.sv - shared types and constants for the Kulisch accumulator (KULISCH_ACC_SATURATE_EN)
package kulisch_seq_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    function automatic int get_acc_bits(input int non_frac, input int frac);
        return non_frac + frac;
    endfunction

    // Clamp limits are built 64 bits wide; the top slices them to the accumulator width.
    function automatic logic [63:0] sat_max(input int acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int acc_w);
        return 64'd1 << (acc_w - 1);
    endfunction

endpackage

// File: rtl/kulisch_seq_accumulator_align.sv
// rtl/kulisch_seq_accumulator_align.sv - places, negates and checks range of one addend
module kulisch_addend_align #(
    parameter int ACC_W      = 32,
    parameter int ADD_BITS   = 10,
    parameter int SHIFT_BITS = 6
) (
    input  logic [ADD_BITS-1:0]   mag,
    input  logic [SHIFT_BITS-1:0] shift,
    input  logic                  sign,
    output logic [ACC_W:0]        addend,
    output logic                  lost_bits
);

    // Wide enough that no magnitude bit can fall off even at the largest shift.
    localparam int WIDE_W = (1 << SHIFT_BITS) + ADD_BITS;

    logic [WIDE_W-1:0] wide;
    logic [ACC_W:0]    mag_ext;

    always_comb begin
        wide      = WIDE_W'(mag) << shift;
        lost_bits = |wide[WIDE_W-1:ACC_W];
        mag_ext   = {1'b0, wide[ACC_W-1:0]};
        addend    = sign ? (~mag_ext + 1'b1) : mag_ext;
    end

endmodule

// File: rtl/kulisch_seq_accumulator.sv
// rtl/kulisch_seq_accumulator.sv - exact fixed-point accumulator with valid/ready sum handoff
// Optional clamp-on-overflow behaviour enabled by defining KULISCH_ACC_SATURATE_EN.
module kulisch_seq_accumulator
    import kulisch_seq_accumulator_pkg::*;
#(
    parameter int ACC_NON_FRAC = 16,
    parameter int ACC_FRAC     = 16,
    parameter int ADD_BITS     = 10,
    parameter int SHIFT_BITS   = 6
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic                                inValid,
    output logic                                inReady,
    input  logic                                inSign,
    input  logic [ADD_BITS-1:0]                 inMag,
    input  logic [SHIFT_BITS-1:0]               inShift,
    input  logic                                inLast,
    output logic                                outValid,
    input  logic                                outReady,
    output logic [ACC_NON_FRAC+ACC_FRAC-1:0]    outAcc,
    output logic                                outOverflow
);

    localparam int ACC_W = get_acc_bits(ACC_NON_FRAC, ACC_FRAC);

`ifdef KULISCH_ACC_SATURATE_EN
    localparam logic [63:0]      SAT_MAX64 = sat_max(ACC_W);
    localparam logic [63:0]      SAT_MIN64 = sat_min(ACC_W);
    localparam logic [ACC_W-1:0] SAT_MAX   = SAT_MAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_MIN   = SAT_MIN64[ACC_W-1:0];
`endif

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic             out_ovf_q, out_ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W:0]   addend;
    logic             lost_bits;
    logic [ACC_W:0]   sum;
    logic             sig_ovf;
    logic             step_ovf;
    logic [ACC_W-1:0] next_acc;

    kulisch_addend_align #(
        .ACC_W      (ACC_W),
        .ADD_BITS   (ADD_BITS),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_align (
        .mag       (inMag),
        .shift     (inShift),
        .sign      (inSign),
        .addend    (addend),
        .lost_bits (lost_bits)
    );

    always_comb begin
        sum      = {acc_q[ACC_W-1], acc_q} + addend;
        sig_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
        step_ovf = lost_bits | sig_ovf;
`ifdef KULISCH_ACC_SATURATE_EN
        // Lost high bits always push in the addend's own direction.
        if (step_ovf) begin
            next_acc = (lost_bits ? inSign : sum[ACC_W]) ? SAT_MIN : SAT_MAX;
        end else begin
            next_acc = sum[ACC_W-1:0];
        end
`else
        next_acc = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                if (inValid) begin
                    if (inLast) begin
                        out_acc_d   = next_acc;
                        out_ovf_d   = ovf_q | step_ovf;
                        acc_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d = next_acc;
                        ovf_d = ovf_q | step_ovf;
                    end
                end
            end
            HOLD: begin
                if (outReady) begin
                    state_d     = ACCUM;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ACCUM;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign inReady     = in_ready_q;
    assign outValid    = out_valid_q;
    assign outAcc      = out_acc_q;
    assign outOverflow = out_ovf_q;

endmodule

// File: tb/tb_kulisch_seq_accumulator.sv
// tb/tb_kulisch_seq_accumulator.sv - self-checking bench for kulisch_seq_accumulator
module tb_kulisch_seq_accumulator;

    logic        clock = 1'b0;
    logic        resetn;
    logic        inValid;
    logic        inReady;
    logic        inSign;
    logic [9:0]  inMag;
    logic [5:0]  inShift;
    logic        inLast;
    logic        outValid;
    logic        outReady;
    logic [31:0] outAcc;
    logic        outOverflow;

    always #5 clock = ~clock;

    kulisch_seq_accumulator dut (
        .clock       (clock),
        .resetn      (resetn),
        .inValid     (inValid),
        .inReady     (inReady),
        .inSign      (inSign),
        .inMag       (inMag),
        .inShift     (inShift),
        .inLast      (inLast),
        .outValid    (outValid),
        .outReady    (outReady),
        .outAcc      (outAcc),
        .outOverflow (outOverflow)
    );

    typedef struct {
        logic        sgn;
        logic [9:0]  mag;
        logic [5:0]  sh;
        logic        last;
        logic [31:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } res_t;

    vec_t vecs[20];
    int   n_vec = 0;
    res_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic sgn, input logic [9:0] mag, input logic [5:0] sh,
                           input logic last, input logic [31:0] ea, input logic eo);
        vecs[n_vec] = '{sgn, mag, sh, last, ea, eo};
        n_vec++;
    endtask

    task automatic send(input logic sgn, input logic [9:0] mag, input logic [5:0] sh, input logic last);
        int waits = 0;
        while (!inReady && waits < 50) begin
            @(posedge clock);
            #1;
            waits++;
        end
        check32("in_ready_before_send", {31'd0, inReady}, 32'd1);
        inValid = 1'b1;
        inSign  = sgn;
        inMag   = mag;
        inShift = sh;
        inLast  = last;
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic expect_result(input logic [31:0] acc, input logic ovf);
        res_t r;
        r.acc = acc;
        r.ovf = ovf;
        sb.push_back(r);
    endtask

    task automatic get_result(input string name);
        int   waits = 0;
        res_t r;
        outReady = 1'b1;
        while (!outValid && waits < 50) begin
            @(posedge clock);
            #1;
            waits++;
        end
        check32({name, "_valid"}, {31'd0, outValid}, 32'd1);
        check32({name, "_latency"}, 32'(waits), 32'd0);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_scoreboard: got output, expected queue empty", name);
        end else begin
            r = sb.pop_front();
            check32({name, "_acc"}, outAcc, r.acc);
            check32({name, "_ovf"}, {31'd0, outOverflow}, {31'd0, r.ovf});
        end
        @(posedge clock);
        #1;
        check32({name, "_valid_drop"}, {31'd0, outValid}, 32'd0);
        check32({name, "_ready_back"}, {31'd0, inReady}, 32'd1);
        outReady = 1'b0;
    endtask

    initial begin
        res_t r;
        resetn   = 1'b0;
        inValid  = 1'b0;
        inSign   = 1'b0;
        inMag    = '0;
        inShift  = '0;
        inLast   = 1'b0;
        outReady = 1'b0;

        add_vec(0, 10'd1,     6'd16, 0, 32'h0, 0);
        add_vec(0, 10'd3,     6'd15, 0, 32'h0, 0);
        add_vec(1, 10'd1,     6'd16, 1, 32'h0001_8000, 0);
        add_vec(1, 10'h3FF,   6'd0,  1, 32'hFFFF_FC01, 0);
        add_vec(0, 10'h3FF,   6'd0,  0, 32'h0, 0);
        add_vec(0, 10'd1,     6'd0,  1, 32'h0000_0400, 0);
        add_vec(0, 10'h200,   6'd22, 0, 32'h0, 0);
`ifdef KULISCH_ACC_SATURATE_EN
        add_vec(0, 10'h200,   6'd22, 1, 32'h7FFF_FFFF, 1);
`else
        add_vec(0, 10'h200,   6'd22, 1, 32'h0000_0000, 1);
`endif
        add_vec(1, 10'h200,   6'd22, 0, 32'h0, 0);
`ifdef KULISCH_ACC_SATURATE_EN
        add_vec(1, 10'h200,   6'd22, 1, 32'h8000_0000, 1);
`else
        add_vec(1, 10'h200,   6'd22, 1, 32'h0000_0000, 1);
`endif
        add_vec(0, 10'h200,   6'd22, 0, 32'h0, 0);
`ifdef KULISCH_ACC_SATURATE_EN
        add_vec(1, 10'h200,   6'd22, 1, 32'hFFFF_FFFF, 1);
        add_vec(0, 10'd1,     6'd40, 1, 32'h7FFF_FFFF, 1);
`else
        add_vec(1, 10'h200,   6'd22, 1, 32'h0000_0000, 1);
        add_vec(0, 10'd1,     6'd40, 1, 32'h0000_0000, 1);
`endif
        add_vec(0, 10'd0,     6'd40, 1, 32'h0000_0000, 0);
`ifdef KULISCH_ACC_SATURATE_EN
        add_vec(1, 10'd1,     6'd40, 1, 32'h8000_0000, 1);
`else
        add_vec(1, 10'd1,     6'd40, 1, 32'h0000_0000, 1);
`endif

        repeat (3) @(posedge clock);
        #1;
        check32("reset_out_valid", {31'd0, outValid}, 32'd0);
        check32("reset_in_ready", {31'd0, inReady}, 32'd1);
        check32("reset_out_acc", outAcc, 32'd0);
        check32("reset_out_ovf", {31'd0, outOverflow}, 32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < n_vec; i++) begin
            send(vecs[i].sgn, vecs[i].mag, vecs[i].sh, vecs[i].last);
            if (vecs[i].last) begin
                expect_result(vecs[i].exp_acc, vecs[i].exp_ovf);
                get_result($sformatf("vec%0d", i));
            end else begin
                check32($sformatf("vec%0d_no_early_valid", i), {31'd0, outValid}, 32'd0);
            end
        end

        // Back-pressure: result must hold and no addend may sneak in.
        send(1'b1, 10'h3FF, 6'd0, 1'b1);
        expect_result(32'hFFFF_FC01, 1'b0);
        r = sb.pop_front();
        inValid = 1'b1;
        inSign  = 1'b0;
        inMag   = 10'd5;
        inShift = 6'd0;
        inLast  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check32("hold_valid", {31'd0, outValid}, 32'd1);
            check32("hold_in_ready", {31'd0, inReady}, 32'd0);
            check32("hold_acc", outAcc, r.acc);
            check32("hold_ovf", {31'd0, outOverflow}, {31'd0, r.ovf});
            @(posedge clock);
            #1;
        end
        outReady = 1'b1;
        @(posedge clock);
        #1;
        inValid  = 1'b0;
        outReady = 1'b0;
        check32("handoff_valid_drop", {31'd0, outValid}, 32'd0);
        check32("handoff_in_ready", {31'd0, inReady}, 32'd1);
        send(1'b0, 10'd1, 6'd0, 1'b1);
        expect_result(32'h0000_0001, 1'b0);
        get_result("after_hold");

        // Reset in the middle of a sum discards it.
        send(1'b0, 10'd1, 6'd16, 1'b0);
        send(1'b0, 10'd7, 6'd3,  1'b0);
        send(1'b1, 10'd2, 6'd31, 1'b0);
        resetn = 1'b0;
        #1;
        check32("midreset_valid", {31'd0, outValid}, 32'd0);
        check32("midreset_in_ready", {31'd0, inReady}, 32'd1);
        check32("midreset_acc", outAcc, 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check32("postreset_no_valid", {31'd0, outValid}, 32'd0);
        send(1'b0, 10'd1, 6'd0, 1'b1);
        expect_result(32'h0000_0001, 1'b0);
        get_result("after_reset");

        check32("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
